regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised register file for the pipelined core: NRD combinational read ports, one write port,
//   write-to-read bypass and a per-register busy scoreboard. Decode reads operands and busy bits here.
//   Issue reserves the destination register; writeback clears the reservation.
//   Hazard logic stalls on rs_busy. Register 0 is hardwired to zero and is never busy.
// PARAMETERS
//   XLEN    32   data width in bits
//   NREGS   32   number of architectural registers, power of two, >= 2
//   NRD     2    number of read ports, >= 1
//   AW      $clog2(NREGS)   address width (derived; do not override)
// PORTS
//   clk          in   1          rising-edge clock
//   rst          in   1          asynchronous active-high reset
//   rs_addr      in   NRD*AW     read addresses, port k = bits [k*AW +: AW]
//   rs_data      out  NRD*XLEN   read data, port k = bits [k*XLEN +: XLEN]
//   rs_busy      out  NRD        port k operand has an outstanding producer
//   rsv_en       in   1          reserve rsv_addr (instruction issued with a destination)
//   rsv_addr     in   AW         destination register being reserved
//   rsv_conflict out  1          rsv_en targets a register still busy after this cycle's writeback (WAW)
//   we           in   1          writeback enable
//   wa           in   AW         writeback address
//   wd           in   XLEN       writeback data
//   flush        in   1          clear all reservations (pipeline squash)
// BEHAVIOUR
//   Reset (async, rst=1):
//     - all registers are 0 and all busy bits are 0 immediately.
//     - rs_data reads 0 and rs_busy reads 0 while rst is held.
//     - rsv_conflict is 0 while rst is held.
//     - clk edges during rst have no effect.
//   Reads (combinational, 0-cycle latency):
//     - addr==0 -> rs_data=0, rs_busy=0.
//     - else if we && wa==addr -> rs_data=wd (bypass), rs_busy=0.
//     - else -> rs_data=reg[addr], rs_busy=busy[addr].
//   Write: at posedge, if we && wa!=0, reg[wa]<=wd. Writes to 0 are discarded.
//   Scoreboard update at posedge, evaluated in priority order:
//     1. flush: busy<=0 for all registers. A concurrent rsv_en is ignored; a concurrent write still commits data.
//     2. else, for each register r:
//        - set if rsv_en && rsv_addr==r && r!=0.
//        - else cleared if we && wa==r.
//        - else held.
//        - If reserve and writeback hit the same r in one cycle, reserve wins and busy stays 1
//          (the new producer supersedes the retiring one).
//   rsv_conflict = rsv_en && rsv_addr!=0 && busy[rsv_addr] && !(we && wa==rsv_addr).
//     - Informational only; the reservation is still taken.
//     - Forced to 0 when flush is 1 or rst is 1.
//   Writeback to a non-busy register is legal: data is written, busy stays 0.
//   All read ports are independent; identical addresses on several ports return identical values.
// STRUCTURE
//   regfile_pkg:
//     - XLEN_DEF, NREGS_DEF.
//     - typedef reg_addr_t (logic [AW-1:0]).
//     - typedef xdata_t (logic [XLEN-1:0]).
//     - constant REG_ZERO = 0.
//   Sub-module busy_scoreboard (NREGS): holds the busy vector and the set/clear/flush priority logic;
//     exposes busy[NREGS-1:0] and rsv_conflict.
//   Top level: storage array, generate loop over NRD read ports with bypass muxes.
// TESTING
//   1. rst pulse mid-run after writing reg5=0xDEADBEEF -> rs_data for a5 = 0 with no clk edge;
//      all rs_busy = 0.
//   2. we=1, wa=7, wd=0x12345678, rs_addr[0]=7 in the same cycle -> rs_data[0]=0x12345678 before the edge
//      and reg7 holds it after the edge.
//   3. we=1, wa=0, wd=0xFFFFFFFF -> reading a0 returns 0;
//      rsv_en with rsv_addr=0 -> rs_busy for a0 stays 0.
//   4. rsv_en for r3; next cycle read a3 -> rs_busy=1.
//      Then we for r3 with wd=0x55 -> same-cycle rs_busy=0, rs_data=0x55; busy[3]=0 after the edge.
//   5. r9 busy; rsv_en r9 and we r9 in the same cycle -> rsv_conflict=0, busy[9]=1 after the edge.
//      rsv_en r9 again with no we -> rsv_conflict=1.
//   6. r2 and r4 busy; flush=1 with rsv_en r6 and we r2 wd=0xA5 ->
//      after the edge all busy=0 (r6 not reserved) and reg2=0xA5.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, types and constants for the register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue/writeback bus of the register file; master is the pipeline, slave the regfile.
import regfile_pkg::*;

interface regfile_scoreboard_if #(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_conflict;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                flush;

  modport master (
    output rs_addr, rsv_en, rsv_addr, we, wa, wd, flush,
    input  rs_data, rs_busy, rsv_conflict
  );

  modport slave (
    input  rs_addr, rsv_en, rsv_addr, we, wa, wd, flush,
    output rs_data, rs_busy, rsv_conflict
  );

endinterface

// File: rtl/busy_scoreboard.sv
// Per-register busy bits: issue reserves, writeback clears, flush squashes everything.
import regfile_pkg::*;

module busy_scoreboard #(
  parameter int unsigned NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rsv_en,
  input  logic [$clog2(NREGS)-1:0] rsv_addr,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy,
  output logic                     rsv_conflict
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_nxt;
  logic             rsv_valid;

  assign rsv_valid = rsv_en && (rsv_addr != AW'(REG_ZERO));

  // Reserve is applied after the clear so a same-cycle new producer keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we)        busy_nxt[wa]       = 1'b0;
      if (rsv_valid) busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rsv_conflict = !rst && !flush && rsv_valid && busy[rsv_addr]
                        && !(we && (wa == rsv_addr));

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NRD bypassed read ports, one write port and a busy scoreboard; r0 reads zero.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2
) (
  input logic                clk,
  input logic                rst,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs    [NREGS];
  logic [XLEN-1:0]  rd_data [NRD];
  logic             rd_busy [NRD];
  logic [NREGS-1:0] busy;

  // Storage; writes to r0 are dropped so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (bus.we && (bus.wa != AW'(REG_ZERO))) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  busy_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .rsv_en       (bus.rsv_en),
    .rsv_addr     (bus.rsv_addr),
    .we           (bus.we),
    .wa           (bus.wa),
    .flush        (bus.flush),
    .busy         (busy),
    .rsv_conflict (bus.rsv_conflict)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero;
    logic          hit;

    assign addr = bus.rs_addr[k*AW +: AW];
    assign zero = rst || (addr == AW'(REG_ZERO));
    assign hit  = bus.we && (bus.wa == addr);

    // A retiring write is forwarded and its producer is no longer outstanding.
    assign rd_data[k] = zero ? '0 : (hit ? bus.wd : regs[addr]);
    assign rd_busy[k] = !zero && !hit && busy[addr];
  end

  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      bus.rs_data[k*XLEN +: XLEN] = rd_data[k];
      bus.rs_busy[k]              = rd_busy[k];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, r0, scoreboard set/clear, WAW and flush.
import regfile_pkg::*;

module tb_regfile_scoreboard;

  localparam int unsigned XLEN = XLEN_DEF;
  localparam int unsigned AW   = AW_DEF;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS_DEF), .NRD(2)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS_DEF), .NRD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.we       = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic rd(input reg_addr_t a0, input reg_addr_t a1);
    bus.rs_addr = {a1, a0};
    #1;
  endtask

  task automatic wr(input reg_addr_t a, input xdata_t d);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
  endtask

  task automatic rsv(input reg_addr_t a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  function automatic xdata_t d0();
    return bus.rs_data[XLEN-1:0];
  endfunction

  function automatic xdata_t d1();
    return bus.rs_data[2*XLEN-1:XLEN];
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    bus.rs_addr = '0;
    #12;
    rd(5'd5, 5'd9);
    check("reset_data", 64'(d0()), 64'h0);
    check("reset_busy", 64'(bus.rs_busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Populate r5, reserve r10, then async reset with no clock edge
    wr(5'd5, 32'hDEADBEEF); tick(); idle();
    rd(5'd5, 5'd10);
    check("r5_written", 64'(d0()), 64'hDEADBEEF);
    rsv(5'd10); tick(); idle();
    rd(5'd5, 5'd10);
    check("r10_busy", 64'(bus.rs_busy), 64'h2);
    rst = 1'b1;
    rsv(5'd10);
    rd(5'd5, 5'd10);
    check("rst_async_data", 64'(d0()), 64'h0);
    check("rst_async_busy", 64'(bus.rs_busy), 64'h0);
    check("rst_conflict", 64'(bus.rsv_conflict), 64'h0);
    idle();
    wr(5'd5, 32'h1111_1111);
    rd(5'd5, 5'd5);
    check("rst_no_bypass", 64'(d0()), 64'h0);
    tick(); idle();
    rst = 1'b0;
    rd(5'd5, 5'd10);
    check("rst_edge_ignored", 64'(d0()), 64'h0);
    check("rst_busy_clear", 64'(bus.rs_busy), 64'h0);

    // Write-to-read bypass on r7, both ports
    wr(5'd7, 32'h12345678);
    rd(5'd7, 5'd7);
    check("bypass_p0", 64'(d0()), 64'h12345678);
    check("bypass_p1", 64'(d1()), 64'h12345678);
    tick(); idle();
    rd(5'd7, 5'd0);
    check("r7_stored", 64'(d0()), 64'h12345678);

    // r0 is hardwired to zero and never busy
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd7);
    check("r0_no_bypass", 64'(d0()), 64'h0);
    tick(); idle();
    rd(5'd0, 5'd7);
    check("r0_no_write", 64'(d0()), 64'h0);
    rsv(5'd0);
    rd(5'd0, 5'd0);
    check("r0_rsv_conflict", 64'(bus.rsv_conflict), 64'h0);
    tick(); idle();
    rd(5'd0, 5'd0);
    check("r0_not_busy", 64'(bus.rs_busy), 64'h0);

    // Reserve r3, then writeback clears it with same-cycle bypass
    rsv(5'd3); tick(); idle();
    rd(5'd3, 5'd7);
    check("r3_busy", 64'(bus.rs_busy), 64'h1);
    wr(5'd3, 32'h55);
    rd(5'd3, 5'd7);
    check("r3_wb_busy", 64'(bus.rs_busy), 64'h0);
    check("r3_wb_data", 64'(d0()), 64'h55);
    tick(); idle();
    rd(5'd3, 5'd7);
    check("r3_after_busy", 64'(bus.rs_busy), 64'h0);
    check("r3_after_data", 64'(d0()), 64'h55);

    // WAW: reserve and writeback on r9 together, then a bare re-reserve
    rsv(5'd9); tick(); idle();
    rsv(5'd9);
    wr(5'd9, 32'h99);
    rd(5'd9, 5'd9);
    check("r9_rsv_wb_conflict", 64'(bus.rsv_conflict), 64'h0);
    tick(); idle();
    rd(5'd9, 5'd0);
    check("r9_still_busy", 64'(bus.rs_busy), 64'h1);
    check("r9_data", 64'(d0()), 64'h99);
    rsv(5'd9);
    rd(5'd9, 5'd0);
    check("r9_waw_conflict", 64'(bus.rsv_conflict), 64'h1);
    tick(); idle();

    // Flush drops all reservations, ignores rsv_en, still commits the write
    rsv(5'd2); tick(); idle();
    rsv(5'd4); tick(); idle();
    rd(5'd2, 5'd4);
    check("r2_r4_busy", 64'(bus.rs_busy), 64'h3);
    bus.flush = 1'b1;
    rsv(5'd9);
    rd(5'd2, 5'd4);
    check("flush_conflict", 64'(bus.rsv_conflict), 64'h0);
    rsv(5'd6);
    wr(5'd2, 32'hA5);
    rd(5'd2, 5'd4);
    tick(); idle();
    rd(5'd2, 5'd4);
    check("flush_r2_r4", 64'(bus.rs_busy), 64'h0);
    check("flush_r2_data", 64'(d0()), 64'hA5);
    rd(5'd6, 5'd9);
    check("flush_r6_r9", 64'(bus.rs_busy), 64'h0);

    // Writeback to a non-busy register leaves it idle
    wr(5'd12, 32'hCAFE0000); tick(); idle();
    rd(5'd12, 5'd12);
    check("nonbusy_wb_busy", 64'(bus.rs_busy), 64'h0);
    check("nonbusy_wb_p1", 64'(d1()), 64'hCAFE0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
